// File: rtl/regfile_pkg.sv
// ============================================================================
// Module  : regfile_pkg
// Brief   : Shared widths and types for the register file and its scoreboard.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package regfile_pkg;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int AW    = $clog2(NREGS);

    typedef logic [AW-1:0]   reg_addr_t;
    typedef logic [XLEN-1:0] xdata_t;

endpackage : regfile_pkg

`default_nettype wire

// File: rtl/regfile_scoreboard.sv
// ============================================================================
// Module  : regfile_scoreboard
// Brief   : Per-register pending bits with flush/issue/writeback priority and
//           a sticky error flag for writebacks to non-pending registers.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module regfile_scoreboard
    import regfile_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en_i,
    input  reg_addr_t        wr_addr_i,
    input  logic             issue_en_i,
    input  reg_addr_t        issue_rd_i,
    input  logic             flush_i,
    output logic [NREGS-1:0] busy_o,
    output logic             wb_err_o
);

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;
    logic             wb_err_q;
    logic             wb_err_d;
    logic             wr_live;
    logic             issue_live;

    assign wr_live    = wr_en_i    && (wr_addr_i  != '0);
    assign issue_live = issue_en_i && (issue_rd_i != '0);

    always_comb begin
        busy_d   = busy_q;
        wb_err_d = wb_err_q;
        if (flush_i) begin
            busy_d = '0;
        end else begin
            if (wr_live) begin
                busy_d[wr_addr_i] = 1'b0;
                if (!busy_q[wr_addr_i]) begin
                    wb_err_d = 1'b1;
                end
            end
            // Applied after the clear so a new producer wins over the completing one.
            if (issue_live) begin
                busy_d[issue_rd_i] = 1'b1;
            end
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q   <= '0;
            wb_err_q <= 1'b0;
        end else begin
            busy_q   <= busy_d;
            wb_err_q <= wb_err_d;
        end
    end

    assign busy_o   = busy_q;
    assign wb_err_o = wb_err_q;

endmodule : regfile_scoreboard

`default_nettype wire

// File: rtl/regfile_sb.sv
// ============================================================================
// Module  : regfile_sb
// Brief   : Integer register file with NRD combinational read ports, one write
//           port, optional write-to-read bypass and an integrated scoreboard.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module regfile_sb
    import regfile_pkg::*;
#(
    parameter int NRD    = 2,
    parameter int BYPASS = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NRD*AW-1:0] rs_addr,
    output logic [NRD*XLEN-1:0] rs_data,
    output logic [NRD-1:0]    rs_hazard,
    input  logic              wr_en,
    input  reg_addr_t         wr_addr,
    input  xdata_t            wr_data,
    input  logic              issue_en,
    input  reg_addr_t         issue_rd,
    input  logic              flush,
    output logic [NREGS-1:0]  busy,
    output logic              wb_err
);

    localparam bit C_BYPASS = (BYPASS != 0);

    xdata_t regs_q [NREGS];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en && (wr_addr != '0)) begin
            regs_q[wr_addr] <= wr_data;
        end
    end

    regfile_scoreboard u_scoreboard (
        .clk        (clk),
        .rst        (rst),
        .wr_en_i    (wr_en),
        .wr_addr_i  (wr_addr),
        .issue_en_i (issue_en),
        .issue_rd_i (issue_rd),
        .flush_i    (flush),
        .busy_o     (busy),
        .wb_err_o   (wb_err)
    );

    // Outputs are forced quiet while reset is held, including the bypass path.
    for (genvar k = 0; k < NRD; k++) begin : g_rd
        reg_addr_t addr;
        logic      fwd;

        assign addr = rs_addr[k*AW +: AW];
        assign fwd  = C_BYPASS && wr_en && (wr_addr == addr) && (addr != '0);

        assign rs_data[k*XLEN +: XLEN] = !rst          ? '0      :
                                         (addr == '0)  ? '0      :
                                         fwd           ? wr_data :
                                                         regs_q[addr];
        assign rs_hazard[k] = rst && busy[addr] && !fwd;
    end : g_rd

endmodule : regfile_sb

`default_nettype wire

// File: tb/tb_regfile_sb.sv
// ============================================================================
// Module  : tb_regfile_sb
// Brief   : Directed plus randomized checks of regfile_sb with and without
//           bypass, against an array-based model of the register file.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_regfile_sb;
    import regfile_pkg::*;

    localparam int NRD = 2;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic [NRD*AW-1:0]    rs_addr;
    logic [NRD*XLEN-1:0]  rs_data, rs_data_nb;
    logic [NRD-1:0]       hz, hz_nb;
    logic                 wr_en;
    reg_addr_t            wr_addr;
    xdata_t               wr_data;
    logic                 issue_en;
    reg_addr_t            issue_rd;
    logic                 flush;
    logic [NREGS-1:0]     busy, busy_nb;
    logic                 wb_err, wb_err_nb;

    int n_checks = 0;
    int n_pass   = 0;

    bit [XLEN-1:0] m_reg  [NREGS];
    bit            m_busy [NREGS];
    bit            m_err;

    always #5 clk = ~clk;

    regfile_sb #(.NRD(NRD), .BYPASS(1)) dut (
        .clk(clk), .rst(rst), .rs_addr(rs_addr), .rs_data(rs_data), .rs_hazard(hz),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .issue_en(issue_en),
        .issue_rd(issue_rd), .flush(flush), .busy(busy), .wb_err(wb_err)
    );

    regfile_sb #(.NRD(NRD), .BYPASS(0)) dut_nb (
        .clk(clk), .rst(rst), .rs_addr(rs_addr), .rs_data(rs_data_nb), .rs_hazard(hz_nb),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .issue_en(issue_en),
        .issue_rd(issue_rd), .flush(flush), .busy(busy_nb), .wb_err(wb_err_nb)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    endtask

    // Reference: architectural state changes only at the edge, from the rules.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREGS; i++) begin
                m_reg[i]  <= '0;
                m_busy[i] <= 1'b0;
            end
            m_err <= 1'b0;
        end else begin
            if (wr_en && wr_addr != 0) begin
                m_reg[wr_addr] <= wr_data;
                if (!flush && !m_busy[wr_addr]) m_err <= 1'b1;
            end
            for (int i = 1; i < NREGS; i++) begin
                automatic bit nb = m_busy[i];
                if (flush) nb = 1'b0;
                else begin
                    if (wr_en && int'(wr_addr) == i) nb = 1'b0;
                    if (issue_en && int'(issue_rd) == i) nb = 1'b1;
                end
                m_busy[i] <= nb;
            end
        end
    end

    function automatic logic [XLEN-1:0] exp_data(input reg_addr_t a, input bit byp);
        if (!rst || a == 0) return '0;
        if (byp && wr_en && wr_addr == a) return wr_data;
        return m_reg[a];
    endfunction

    function automatic logic exp_hz(input reg_addr_t a, input bit byp);
        if (!rst) return 1'b0;
        return m_busy[a] && !(byp && wr_en && wr_addr == a);
    endfunction

    function automatic logic [NREGS-1:0] exp_busy();
        logic [NREGS-1:0] v;
        for (int i = 0; i < NREGS; i++) v[i] = m_busy[i];
        return v;
    endfunction

    // Every cycle, both instances are compared against the model.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            for (int k = 0; k < NRD; k++) begin
                automatic reg_addr_t a = rs_addr[k*AW +: AW];
                check($sformatf("data_byp[%0d]", k), 64'(rs_data[k*XLEN +: XLEN]), 64'(exp_data(a, 1'b1)));
                check($sformatf("data_nb[%0d]", k), 64'(rs_data_nb[k*XLEN +: XLEN]), 64'(exp_data(a, 1'b0)));
                check($sformatf("hz_byp[%0d]", k), 64'(hz[k]), 64'(exp_hz(a, 1'b1)));
                check($sformatf("hz_nb[%0d]", k), 64'(hz_nb[k]), 64'(exp_hz(a, 1'b0)));
            end
            check("busy_byp", 64'(busy), 64'(exp_busy()));
            check("busy_nb", 64'(busy_nb), 64'(exp_busy()));
            check("wb_err_byp", 64'(wb_err), 64'(m_err));
            check("wb_err_nb", 64'(wb_err_nb), 64'(m_err));
        end
    end

    task automatic idle();
        wr_en    = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        issue_en = 1'b0;
        issue_rd = '0;
        flush    = 1'b0;
    endtask

    task automatic set_rs(input int a1, input int a0);
        rs_addr = {reg_addr_t'(a1), reg_addr_t'(a0)};
    endtask

    task automatic do_issue(input int rd);
        issue_en = 1'b1;
        issue_rd = reg_addr_t'(rd);
    endtask

    task automatic do_write(input int a, input logic [XLEN-1:0] d);
        wr_en   = 1'b1;
        wr_addr = reg_addr_t'(a);
        wr_data = d;
    endtask

    initial begin
        idle();
        set_rs(0, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // Fill every register; each fill also issues it, so all end up pending.
        for (int r = 1; r < NREGS; r++) begin
            @(negedge clk); idle();
            do_write(r, 32'hA5A5A5A5);
            do_issue(r);
        end
        @(negedge clk); idle(); set_rs(9, 5);
        #1;
        check("fill_data", 64'(rs_data[31:0]), 64'h0000_0000_A5A5_A5A5);
        check("fill_busy", 64'(busy), 64'h0000_0000_FFFF_FFFE);
        check("fill_err", 64'(wb_err), 64'h1);
        do_write(5, 32'h1111_2222);
        #2;
        rst = 1'b0;
        #1;
        check("rst_data", 64'(rs_data), 64'h0);
        check("rst_hz", 64'(hz), 64'h0);
        check("rst_busy", 64'(busy), 64'h0);
        check("rst_err", 64'(wb_err), 64'h0);
        @(negedge clk); idle(); rst = 1'b1;
        #1;
        check("post_rst_r5", 64'(rs_data[31:0]), 64'h0);

        // Register 0 ignores writes and issues.
        @(negedge clk); idle(); set_rs(0, 0);
        do_write(0, 32'hDEADBEEF); do_issue(0);
        #1;
        check("x0_data", 64'(rs_data), 64'h0);
        @(negedge clk); idle();
        #1;
        check("x0_busy", 64'(busy), 64'h0);
        check("x0_err", 64'(wb_err), 64'h0);

        // Bypass versus stored value.
        @(negedge clk); idle(); do_issue(5);
        @(negedge clk); idle(); set_rs(5, 5); do_write(5, 32'h12345678);
        #1;
        check("byp_data", 64'(rs_data), 64'h12345678_12345678);
        check("nb_data", 64'(rs_data_nb), 64'h0);
        check("byp_hz", 64'(hz), 64'h0);
        check("nb_hz", 64'(hz_nb), 64'h3);
        @(negedge clk); idle();
        #1;
        check("nb_data_after", 64'(rs_data_nb[31:0]), 64'h12345678);

        // Issue then writeback of r3.
        @(negedge clk); idle(); set_rs(3, 3); do_issue(3);
        #1;
        check("issue_no_self_hz", 64'(hz), 64'h0);
        @(negedge clk); idle();
        #1;
        check("r3_hz", 64'(hz), 64'h3);
        check("r3_busy", 64'(busy), 64'h8);
        @(negedge clk); idle(); do_write(3, 32'h33);
        #1;
        check("r3_wb_hz_byp", 64'(hz), 64'h0);
        check("r3_wb_hz_nb", 64'(hz_nb), 64'h3);
        @(negedge clk); idle();
        #1;
        check("r3_busy_clr", 64'(busy), 64'h0);
        check("r3_hz_nb_clr", 64'(hz_nb), 64'h0);

        // Collision: new producer on the register being written back.
        @(negedge clk); idle(); do_issue(7);
        @(negedge clk); idle(); do_write(7, 32'hCAFE0007); do_issue(7);
        @(negedge clk); idle(); set_rs(7, 7);
        #1;
        check("coll_busy", 64'(busy), 64'h80);
        check("coll_data", 64'(rs_data_nb[31:0]), 64'hCAFE0007);
        check("coll_err", 64'(wb_err), 64'h0);

        // Flush discards pending and the same-cycle issue; late write is an error.
        @(negedge clk); idle(); do_issue(2);
        @(negedge clk); idle(); do_issue(9);
        @(negedge clk); idle(); flush = 1'b1; do_issue(4);
        @(negedge clk); idle();
        #1;
        check("flush_busy", 64'(busy), 64'h0);
        check("flush_err", 64'(wb_err), 64'h0);
        do_write(9, 32'h99);
        @(negedge clk); idle();
        #1;
        check("late_wb_err", 64'(wb_err), 64'h1);
        repeat (3) @(negedge clk);
        #1;
        check("late_wb_sticky", 64'(wb_err), 64'h1);

        @(negedge clk); rst = 1'b0;
        @(negedge clk); rst = 1'b1;

        // Randomized traffic on a narrow address window to provoke collisions.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            idle();
            rst = ($urandom_range(0, 199) != 0);
            if ($urandom_range(0, 99) < 45) do_write($urandom_range(0, 7), $urandom);
            if ($urandom_range(0, 99) < 45) do_issue($urandom_range(0, 7));
            flush = ($urandom_range(0, 99) < 4);
            set_rs($urandom_range(0, 7), $urandom_range(0, 7));
            if ($urandom_range(0, 9) == 0) begin
                wr_addr = reg_addr_t'($urandom_range(0, NREGS - 1));
                set_rs($urandom_range(0, NREGS - 1), int'(wr_addr));
            end
        end

        @(negedge clk); idle(); rst = 1'b1;
        @(negedge clk);
        #3;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_regfile_sb

`default_nettype wire
